// File: rtl/tcm_arb_pkg.sv
// tcm_arb_pkg: owner ids and arbitration-mode constants shared by the TCM data-port arbiter
package tcm_arb_pkg;
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_ACC = 1'b1;
    localparam int PRIO_RR = 0;
    localparam int PRIO_FIXED = 1;
endpackage

// File: rtl/tcm_dport_arbiter_if.sv
// tcm_dport_arbiter_if: one TCM-style data-port bus (request fields out, accept/response back)
// master drives addr/data_wr/rd/wr/req_tag; slave drives accept/ack/error/resp_tag/data_rd
interface tcm_dport_arbiter_if;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic rd;
    logic [3:0] wr;
    logic [10:0] req_tag;
    logic accept;
    logic ack;
    logic error;
    logic [10:0] resp_tag;
    logic [31:0] data_rd;
    modport master(output addr, data_wr, rd, wr, req_tag, input accept, ack, error, resp_tag, data_rd);
    modport slave(input addr, data_wr, rd, wr, req_tag, output accept, ack, error, resp_tag, data_rd);
endinterface

// File: rtl/tcm_arb_owner_fifo.sv
// tcm_arb_owner_fifo: 1-bit owner-id FIFO recording which requester issued each in-flight TCM request
// ports: clk_i/rst_i, push_i+din_i write, pop_i read, dout_o head, count_o/full_o/empty_o status
module tcm_arb_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic dout_o,
    output logic [W:0] count_o,
    output logic full_o,
    output logic empty_o
);
    logic [DEPTH-1:0] mem_q;
    logic [W-1:0] wr_q, rd_q;
    logic [W:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) mem_q[wr_q] <= din_i;
            wr_q <= wr_q + W'(push_i);
            rd_q <= rd_q + W'(pop_i);
            cnt_q <= cnt_q + (W+1)'(push_i) - (W+1)'(pop_i);
        end
    end
    assign dout_o = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o = cnt_q == (W+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/tcm_dport_arbiter.sv
// tcm_dport_arbiter: shares the TCM data port between the CPU dport path and the accelerator master
// ports: clk_i/rst_i; cpu_if/acc_if requester buses (slave); tcm_if TCM port (master);
//        outstanding_o in-flight count; unexp_ack_o sticky ack-with-nothing-outstanding flag
module tcm_dport_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int OUTSTANDING_W = 2,
    parameter int PRIO_MODE = PRIO_RR,
    parameter int STARVE_MAX = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    tcm_dport_arbiter_if.slave cpu_if,
    tcm_dport_arbiter_if.slave acc_if,
    tcm_dport_arbiter_if.master tcm_if,
    output logic [OUTSTANDING_W:0] outstanding_o,
    output logic unexp_ack_o
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    logic lock_q, lock_d, owner_lock_q, owner_lock_d, last_q, last_d, unexp_q, unexp_d;
    logic [SW-1:0] starve_q, starve_d;
    logic cpu_v, acc_v, sel, gnt, issue, pop, full, empty, head;
    tcm_arb_owner_fifo #(.DEPTH(OUTSTANDING), .W(OUTSTANDING_W)) u_fifo (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .push_i(issue),
        .pop_i(pop),
        .din_i(sel),
        .dout_o(head),
        .count_o(outstanding_o),
        .full_o(full),
        .empty_o(empty)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
            owner_lock_q <= OWNER_CPU;
            last_q <= OWNER_ACC;
            starve_q <= '0;
            unexp_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            owner_lock_q <= owner_lock_d;
            last_q <= last_d;
            starve_q <= starve_d;
            unexp_q <= unexp_d;
        end
    end
    always_comb begin
        cpu_v = cpu_if.rd | (|cpu_if.wr);
        acc_v = acc_if.rd | (|acc_if.wr);
        // a pending unaccepted grant pins the owner; otherwise ties go by mode
        sel = lock_q ? owner_lock_q
            : (cpu_v && acc_v) ? (PRIO_MODE == PRIO_FIXED ? (starve_q == STARVE_LIM ? OWNER_ACC : OWNER_CPU)
                                                          : (last_q == OWNER_CPU ? OWNER_ACC : OWNER_CPU))
            : (acc_v ? OWNER_ACC : OWNER_CPU);
        gnt = !full && !rst_i && (lock_q || cpu_v || acc_v);
        issue = gnt && tcm_if.accept;
        tcm_if.addr = sel == OWNER_ACC ? acc_if.addr : cpu_if.addr;
        tcm_if.data_wr = sel == OWNER_ACC ? acc_if.data_wr : cpu_if.data_wr;
        tcm_if.req_tag = sel == OWNER_ACC ? acc_if.req_tag : cpu_if.req_tag;
        tcm_if.rd = gnt && (sel == OWNER_ACC ? acc_if.rd : cpu_if.rd);
        tcm_if.wr = gnt ? (sel == OWNER_ACC ? acc_if.wr : cpu_if.wr) : 4'b0;
        cpu_if.accept = issue && sel == OWNER_CPU;
        acc_if.accept = issue && sel == OWNER_ACC;
        pop = tcm_if.ack && !empty && !rst_i;
        cpu_if.ack = pop && head == OWNER_CPU;
        acc_if.ack = pop && head == OWNER_ACC;
        cpu_if.error = tcm_if.error;
        acc_if.error = tcm_if.error;
        cpu_if.resp_tag = tcm_if.resp_tag;
        acc_if.resp_tag = tcm_if.resp_tag;
        cpu_if.data_rd = tcm_if.data_rd;
        acc_if.data_rd = tcm_if.data_rd;
        lock_d = gnt ? !tcm_if.accept : lock_q;
        owner_lock_d = gnt ? sel : owner_lock_q;
        last_d = issue ? sel : last_q;
        // saturating so a CPU lock while already starved cannot wrap past the limit
        starve_d = (issue && sel == OWNER_ACC) ? '0
                 : (acc_v && gnt && sel == OWNER_CPU && starve_q != STARVE_LIM) ? starve_q + SW'(1)
                 : starve_q;
        unexp_d = unexp_q | (tcm_if.ack && empty);
        unexp_ack_o = unexp_q;
    end
endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// tb_tcm_dport_arbiter: directed and randomized self-checking bench for tcm_dport_arbiter
module tb_tcm_dport_arbiter;
    import tcm_arb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    tcm_dport_arbiter_if c0(), a0(), t0(), c1(), a1(), t1();
    logic [2:0] out0, out1;
    logic unexp0, unexp1;
    tcm_dport_arbiter #(.PRIO_MODE(PRIO_RR)) dut_rr (
        .clk_i(clk), .rst_i(rst), .cpu_if(c0), .acc_if(a0), .tcm_if(t0),
        .outstanding_o(out0), .unexp_ack_o(unexp0)
    );
    tcm_dport_arbiter #(.PRIO_MODE(PRIO_FIXED)) dut_fx (
        .clk_i(clk), .rst_i(rst), .cpu_if(c1), .acc_if(a1), .tcm_if(t1),
        .outstanding_o(out1), .unexp_ack_o(unexp1)
    );
    typedef struct {
        bit own;
        logic [10:0] tag;
    } ent_t;
    ent_t mq[$];
    ent_t e;
    int total = 0;
    int bad = 0;
    bit m_last, m_lock, m_lown, cp, ap, gv, sel, own;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task tick;
        @(posedge clk);
        #1;
    endtask
    task zero;
        c0.rd = 0; c0.wr = 0; c0.addr = 0; c0.data_wr = 0; c0.req_tag = 0;
        a0.rd = 0; a0.wr = 0; a0.addr = 0; a0.data_wr = 0; a0.req_tag = 0;
        c1.rd = 0; c1.wr = 0; c1.addr = 0; c1.data_wr = 0; c1.req_tag = 0;
        a1.rd = 0; a1.wr = 0; a1.addr = 0; a1.data_wr = 0; a1.req_tag = 0;
        t0.accept = 0; t0.ack = 0; t0.error = 0; t0.resp_tag = 0; t0.data_rd = 0;
        t1.accept = 0; t1.ack = 0; t1.error = 0; t1.resp_tag = 0; t1.data_rd = 0;
    endtask
    initial begin
        zero;
        c0.rd = 1; c0.addr = 32'h40; t0.accept = 1; t0.ack = 1;
        tick;
        @(negedge clk);
        chk("rst_cpu_accept", c0.accept, 0);
        chk("rst_acc_accept", a0.accept, 0);
        chk("rst_tcm_rd", t0.rd, 0);
        chk("rst_cpu_ack", c0.ack, 0);
        chk("rst_count", out0, 0);
        chk("rst_unexp", unexp0, 0);
        tick;
        zero;
        rst = 0;
        c0.rd = 1; c0.addr = 32'h100; c0.req_tag = 11'h005; t0.accept = 1;
        @(negedge clk);
        chk("cpu_rd_accept", c0.accept, 1);
        chk("cpu_rd_acc_accept", a0.accept, 0);
        chk("cpu_rd_tcm_addr", t0.addr, 32'h100);
        chk("cpu_rd_tcm_tag", t0.req_tag, 11'h005);
        chk("cpu_rd_tcm_rd", t0.rd, 1);
        tick;
        c0.rd = 0; t0.accept = 0; t0.ack = 1; t0.resp_tag = 11'h005; t0.data_rd = 32'hDEADBEEF;
        @(negedge clk);
        chk("cpu_rd_count", out0, 1);
        chk("cpu_rd_ack", c0.ack, 1);
        chk("cpu_rd_resp_tag", c0.resp_tag, 11'h005);
        chk("cpu_rd_data", c0.data_rd, 32'hDEADBEEF);
        chk("cpu_rd_acc_ack", a0.ack, 0);
        tick;
        t0.ack = 0;
        @(negedge clk);
        chk("cpu_rd_drained", out0, 0);
        tick;
        // round robin: last winner was CPU, so ACC leads
        c0.rd = 1; c0.addr = 32'h200; c0.req_tag = 11'h011;
        a0.rd = 1; a0.addr = 32'h300; a0.req_tag = 11'h022;
        t0.accept = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_acc_accept", a0.accept, (i % 2) == 0);
            chk("rr_cpu_accept", c0.accept, (i % 2) == 1);
            chk("rr_tcm_tag", t0.req_tag, (i % 2) == 0 ? 11'h022 : 11'h011);
            tick;
        end
        c0.rd = 0; a0.rd = 0; t0.accept = 0;
        @(negedge clk);
        chk("rr_count4", out0, 4);
        tick;
        for (int i = 0; i < 4; i++) begin
            t0.ack = 1;
            t0.resp_tag = (i % 2) == 0 ? 11'h022 : 11'h011;
            @(negedge clk);
            chk("rr_resp_acc_ack", a0.ack, (i % 2) == 0);
            chk("rr_resp_cpu_ack", c0.ack, (i % 2) == 1);
            chk("rr_resp_count", out0, 4 - i);
            tick;
        end
        t0.ack = 0;
        a0.rd = 1; a0.addr = 32'h300; a0.req_tag = 11'h022; t0.accept = 1;
        @(negedge clk);
        chk("pre_lock_acc_accept", a0.accept, 1);
        tick;
        a0.rd = 0; t0.accept = 0; t0.ack = 1; t0.resp_tag = 11'h022;
        @(negedge clk);
        chk("pre_lock_acc_ack", a0.ack, 1);
        tick;
        // last winner is ACC now; a lock must still keep ACC against the CPU
        t0.ack = 0;
        a0.wr = 4'hF; a0.addr = 32'h400; a0.req_tag = 11'h033;
        @(negedge clk);
        chk("lock_tcm_wr", t0.wr, 4'hF);
        chk("lock_acc_accept0", a0.accept, 0);
        tick;
        c0.rd = 1; c0.addr = 32'h500; c0.req_tag = 11'h044;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lock_hold_addr", t0.addr, 32'h400);
            chk("lock_cpu_accept", c0.accept, 0);
            tick;
        end
        t0.accept = 1;
        @(negedge clk);
        chk("lock_release_acc", a0.accept, 1);
        chk("lock_release_cpu", c0.accept, 0);
        tick;
        a0.wr = 0;
        @(negedge clk);
        chk("lock_after_cpu", c0.accept, 1);
        tick;
        c0.rd = 0; t0.accept = 0; t0.ack = 1; t0.resp_tag = 11'h033;
        @(negedge clk);
        chk("lock_resp_acc", a0.ack, 1);
        tick;
        t0.resp_tag = 11'h044;
        @(negedge clk);
        chk("lock_resp_cpu", c0.ack, 1);
        chk("lock_resp_cpu_tag", c0.resp_tag, 11'h044);
        tick;
        zero;
        rst = 1;
        tick;
        rst = 0;
        c0.rd = 1; t0.accept = 1;
        for (int i = 0; i < 4; i++) begin
            c0.req_tag = 11'(i);
            @(negedge clk);
            chk("full_fill_accept", c0.accept, 1);
            tick;
        end
        t0.ack = 1; t0.resp_tag = 0;
        @(negedge clk);
        chk("full_count", out0, 4);
        chk("full_blocked_accept", c0.accept, 0);
        chk("full_blocked_rd", t0.rd, 0);
        chk("full_pop_ack", c0.ack, 1);
        tick;
        c0.req_tag = 11'h004; t0.resp_tag = 11'h001;
        @(negedge clk);
        chk("full_after_pop_count", out0, 3);
        chk("full_after_pop_accept", c0.accept, 1);
        chk("pushpop_ack", c0.ack, 1);
        tick;
        c0.rd = 0; t0.ack = 0; t0.accept = 0;
        @(negedge clk);
        chk("pushpop_count", out0, 3);
        tick;
        zero;
        rst = 1;
        tick;
        rst = 0;
        t0.ack = 1;
        @(negedge clk);
        chk("unexp_cpu_ack", c0.ack, 0);
        chk("unexp_acc_ack", a0.ack, 0);
        tick;
        t0.ack = 0;
        @(negedge clk);
        chk("unexp_set", unexp0, 1);
        chk("unexp_count", out0, 0);
        tick;
        tick;
        @(negedge clk);
        chk("unexp_sticky", unexp0, 1);
        rst = 1;
        tick;
        rst = 0;
        @(negedge clk);
        chk("unexp_cleared", unexp0, 0);
        tick;
        c0.rd = 1; t0.accept = 1;
        @(negedge clk);
        chk("midrst_accept", c0.accept, 1);
        tick;
        c0.rd = 0; t0.accept = 0; rst = 1;
        tick;
        rst = 0; t0.ack = 1;
        @(negedge clk);
        chk("midrst_count", out0, 0);
        chk("midrst_no_ack", c0.ack, 0);
        tick;
        t0.ack = 0;
        @(negedge clk);
        chk("midrst_unexp", unexp0, 1);
        tick;
        // fixed priority: CPU wins 8 times, then ACC wins once
        rst = 1;
        tick;
        rst = 0;
        c1.rd = 1; c1.addr = 32'h600; a1.rd = 1; a1.addr = 32'h700; t1.accept = 1;
        for (int k = 0; k < 10; k++) begin
            t1.ack = k > 0;
            @(negedge clk);
            chk("fx_cpu_accept", c1.accept, k != 8);
            chk("fx_acc_accept", a1.accept, k == 8);
            tick;
        end
        zero;
        rst = 1;
        tick;
        rst = 0;
        mq.delete();
        m_last = 1; m_lock = 0; m_lown = 0; cp = 0; ap = 0;
        for (int n = 0; n < 400; n++) begin
            if (!cp && $urandom_range(0, 2) != 0) begin
                cp = 1;
                c0.rd = 1'($urandom);
                c0.wr = c0.rd ? 4'h0 : 4'($urandom_range(1, 15));
                c0.addr = $urandom; c0.data_wr = $urandom; c0.req_tag = 11'($urandom);
            end
            if (!cp) begin c0.rd = 0; c0.wr = 0; end
            if (!ap && $urandom_range(0, 2) != 0) begin
                ap = 1;
                a0.rd = 1'($urandom);
                a0.wr = a0.rd ? 4'h0 : 4'($urandom_range(1, 15));
                a0.addr = $urandom; a0.data_wr = $urandom; a0.req_tag = 11'($urandom);
            end
            if (!ap) begin a0.rd = 0; a0.wr = 0; end
            t0.accept = $urandom_range(0, 3) != 0;
            t0.ack = mq.size() > 0 && $urandom_range(0, 1) == 1;
            t0.resp_tag = mq.size() > 0 ? mq[0].tag : 11'h0;
            t0.data_rd = $urandom;
            t0.error = 1'($urandom);
            @(negedge clk);
            gv = mq.size() < 4 && (cp || ap);
            sel = m_lock ? m_lown : (cp && ap) ? !m_last : ap;
            chk("rnd_cpu_accept", c0.accept, gv && !sel && t0.accept);
            chk("rnd_acc_accept", a0.accept, gv && sel && t0.accept);
            chk("rnd_tcm_rdwr", {t0.rd, t0.wr}, !gv ? 5'h0 : sel ? {a0.rd, a0.wr} : {c0.rd, c0.wr});
            if (gv) chk("rnd_tcm_addr_tag", {t0.req_tag, t0.addr}, sel ? {a0.req_tag, a0.addr} : {c0.req_tag, c0.addr});
            chk("rnd_count", out0, mq.size());
            if (t0.ack) begin
                own = mq[0].own;
                chk("rnd_cpu_ack", c0.ack, !own);
                chk("rnd_acc_ack", a0.ack, own);
                chk("rnd_resp_tag", own ? a0.resp_tag : c0.resp_tag, mq[0].tag);
                chk("rnd_resp_data", {own ? a0.error : c0.error, own ? a0.data_rd : c0.data_rd}, {t0.error, t0.data_rd});
            end else chk("rnd_no_ack", {c0.ack, a0.ack}, 2'b00);
            if (gv && t0.accept) begin
                e.own = sel;
                e.tag = sel ? a0.req_tag : c0.req_tag;
                mq.push_back(e);
                m_last = sel;
                m_lock = 0;
                if (sel) ap = 0; else cp = 0;
            end else if (gv) begin
                m_lock = 1;
                m_lown = sel;
            end
            if (t0.ack) void'(mq.pop_front());
            tick;
        end
        @(negedge clk);
        chk("rnd_unexp", unexp0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
